// File: rtl/mem_ctrl_pkg.sv
// Shared widths, constants and the IO-region decode for the memory controller.
package mem_ctrl_pkg;

  localparam int unsigned AddrW   = 32;
  localparam int unsigned InsW    = 32;
  localparam int unsigned StatusW = 1;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam logic [AddrW-1:0] ZeroAddr = '0;
  localparam logic [InsW-1:0]  ZeroWord = '0;

  // Addresses with bits [17:16] == 2'b11 map onto the IO sink.
  localparam logic [1:0] IoRegion = 2'b11;

  function automatic logic is_io_addr(input logic [AddrW-1:0] addr);
    return addr[17:16] == IoRegion;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide RAM arbiter serving instruction fetch and load/store requests.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [7:0]         mem_din,
  output logic [7:0]         mem_dout,
  output logic [AddrW-1:0]   mem_a,
  output logic               mem_wr,
  input  logic               io_buffer_full,
  input  logic               ena_from_if,
  input  logic [AddrW-1:0]   pc_from_if,
  input  logic               drop_flag_from_if,
  output logic [StatusW-1:0] ok_flag_to_if,
  output logic [InsW-1:0]    inst_to_if,
  input  logic               ena_from_lsb,
  input  logic               wr_flag_from_lsb,
  input  logic [AddrW-1:0]   addr_from_lsb,
  input  logic [2:0]         size_from_lsb,
  input  logic [InsW-1:0]    data_from_lsb,
  output logic [StatusW-1:0] ok_flag_to_lsb,
  output logic [InsW-1:0]    data_to_lsb
);

  typedef enum logic [1:0] {StIdle, StIfRead, StLsRead, StLsWrite} state_e;

  state_e           state_q;
  logic             if_pend_q;
  logic [AddrW-1:0] if_addr_q;
  logic             lsb_pend_q;
  logic             lsb_wr_q;
  logic [AddrW-1:0] lsb_addr_q;
  logic [2:0]       lsb_size_q;
  logic [InsW-1:0]  lsb_data_q;
  logic [AddrW-1:0] base_q;
  logic [2:0]       len_q;
  logic [InsW-1:0]  wdata_q;
  logic [InsW-1:0]  rdata_q;
  logic [3:0]       cnt_q;      // edges elapsed since the first address went out
  logic             mem_wr_q;

  logic [AddrW-1:0] cur_addr;
  logic [1:0]       cap_idx;
  logic [1:0]       wr_idx;
  logic [InsW-1:0]  rdata_merged;
  logic [3:0]       last_cnt;
  logic             wr_stall;

  // A frozen controller must never leave a write strobe asserted on the bus.
  assign mem_wr = mem_wr_q & rdy;

  // Address step, byte lane bookkeeping and the IO back-pressure decode.
  always_comb begin
    cur_addr     = base_q + AddrW'(cnt_q);
    cap_idx      = 2'(cnt_q - 4'd2);            // RAM data trails the address by two edges
    wr_idx       = cnt_q[1:0];
    rdata_merged = rdata_q | (InsW'(mem_din) << {cap_idx, 3'b000});
    last_cnt     = {1'b0, len_q} + 4'd1;
    wr_stall     = io_buffer_full && is_io_addr(cur_addr);
  end

  // Request capture plus the access sequencer; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      if_pend_q      <= False;
      if_addr_q      <= ZeroAddr;
      lsb_pend_q     <= False;
      lsb_wr_q       <= False;
      lsb_addr_q     <= ZeroAddr;
      lsb_size_q     <= 3'd0;
      lsb_data_q     <= ZeroWord;
      base_q         <= ZeroAddr;
      len_q          <= 3'd0;
      wdata_q        <= ZeroWord;
      rdata_q        <= ZeroWord;
      cnt_q          <= 4'd0;
      mem_wr_q       <= False;
      mem_a          <= ZeroAddr;
      mem_dout       <= 8'h00;
      ok_flag_to_if  <= False;
      ok_flag_to_lsb <= False;
      inst_to_if     <= ZeroWord;
      data_to_lsb    <= ZeroWord;
    end else if (rdy) begin
      ok_flag_to_if  <= False;
      ok_flag_to_lsb <= False;
      mem_wr_q       <= False;

      // A drop wins over a fetch pulse arriving in the same cycle.
      if (drop_flag_from_if) begin
        if_pend_q <= False;
      end else if (ena_from_if) begin
        if_pend_q <= True;
        if_addr_q <= pc_from_if;
      end
      if (ena_from_lsb) begin
        lsb_pend_q <= True;
        lsb_wr_q   <= wr_flag_from_lsb;
        lsb_addr_q <= addr_from_lsb;
        lsb_size_q <= size_from_lsb;
        lsb_data_q <= data_from_lsb;
      end

      unique case (state_q)
        StIdle: begin
          // Load/store traffic has priority; byte 0 is issued on the accepting edge.
          if (lsb_pend_q) begin
            lsb_pend_q <= False;
            base_q     <= lsb_addr_q;
            len_q      <= lsb_size_q;
            wdata_q    <= lsb_data_q;
            rdata_q    <= ZeroWord;
            if (lsb_wr_q) begin
              state_q <= StLsWrite;
              if (io_buffer_full && is_io_addr(lsb_addr_q)) begin
                cnt_q <= 4'd0;
              end else begin
                mem_wr_q <= True;
                mem_a    <= lsb_addr_q;
                mem_dout <= lsb_data_q[7:0];
                cnt_q    <= 4'd1;
              end
            end else begin
              state_q <= StLsRead;
              mem_a   <= lsb_addr_q;
              cnt_q   <= 4'd1;
            end
          end else if (if_pend_q && !drop_flag_from_if) begin
            if_pend_q <= False;
            base_q    <= if_addr_q;
            len_q     <= 3'd4;
            rdata_q   <= ZeroWord;
            state_q   <= StIfRead;
            mem_a     <= if_addr_q;
            cnt_q     <= 4'd1;
          end
        end
        StIfRead, StLsRead: begin
          if (state_q == StIfRead && drop_flag_from_if) begin
            state_q <= StIdle;
          end else begin
            if (cnt_q < {1'b0, len_q}) mem_a <= cur_addr;
            if (cnt_q >= 4'd2) rdata_q <= rdata_merged;
            if (cnt_q == last_cnt) begin
              if (state_q == StIfRead) begin
                ok_flag_to_if <= True;
                inst_to_if    <= rdata_merged;
              end else begin
                ok_flag_to_lsb <= True;
                data_to_lsb    <= rdata_merged;
              end
              state_q <= StIdle;
            end
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StLsWrite: begin
          if (cnt_q == {1'b0, len_q}) begin
            ok_flag_to_lsb <= True;
            state_q        <= StIdle;
          end else if (!wr_stall) begin
            mem_wr_q <= True;
            mem_a    <= cur_addr;
            mem_dout <= wdata_q[{wr_idx, 3'b000} +: 8];
            cnt_q    <= cnt_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: sparse byte RAM, directed scenarios, randomized traffic.
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;
  logic        ena_from_if = 1'b0;
  logic [31:0] pc_from_if = '0;
  logic        drop_flag_from_if = 1'b0;
  logic        ok_flag_to_if;
  logic [31:0] inst_to_if;
  logic        ena_from_lsb = 1'b0;
  logic        wr_flag_from_lsb = 1'b0;
  logic [31:0] addr_from_lsb = '0;
  logic [2:0]  size_from_lsb = '0;
  logic [31:0] data_from_lsb = '0;
  logic        ok_flag_to_lsb;
  logic [31:0] data_to_lsb;

  mem_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .mem_din          (mem_din),
    .mem_dout         (mem_dout),
    .mem_a            (mem_a),
    .mem_wr           (mem_wr),
    .io_buffer_full   (io_buffer_full),
    .ena_from_if      (ena_from_if),
    .pc_from_if       (pc_from_if),
    .drop_flag_from_if(drop_flag_from_if),
    .ok_flag_to_if    (ok_flag_to_if),
    .inst_to_if       (inst_to_if),
    .ena_from_lsb     (ena_from_lsb),
    .wr_flag_from_lsb (wr_flag_from_lsb),
    .addr_from_lsb    (addr_from_lsb),
    .size_from_lsb    (size_from_lsb),
    .data_from_lsb    (data_from_lsb),
    .ok_flag_to_lsb   (ok_flag_to_lsb),
    .data_to_lsb      (data_to_lsb)
  );

  always #5 clk = ~clk;

  typedef struct {bit wr; logic [31:0] data;} lsb_exp_t;
  typedef struct {logic [31:0] a; logic [7:0] d;} wr_exp_t;

  logic [7:0]  ram     [bit [31:0]];   // what the DUT actually sees and writes
  logic [7:0]  ref_mem [bit [31:0]];   // what memory should contain
  logic [31:0] if_q[$];
  lsb_exp_t    lsb_q[$];
  wr_exp_t     wr_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int if_ok_cnt = 0;
  int lsb_ok_cnt = 0;
  int last_if_ok = 0;
  int last_lsb_ok = 0;
  bit rnd_done = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Little-endian, zero-extended read of n bytes with 32-bit address wrap.
  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w |= 32'(ref_byte(a + 32'(i))) << (8 * i);
    return w;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  // RAM with one cycle of read latency; frozen together with the controller.
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
      if (mem_wr) ram[mem_a] = mem_dout;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT presents a write byte or an ok pulse.
  always @(negedge clk) begin : monitor
    wr_exp_t  we;
    lsb_exp_t le;
    if (!rst) begin
      if (mem_wr) begin
        check("write_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          we = wr_q.pop_front();
          check("write_addr", mem_a, we.a);
          check("write_data", 32'(mem_dout), 32'(we.d));
        end
      end
      if (ok_flag_to_if) begin
        if_ok_cnt++;
        last_if_ok = cyc;
        check("if_ok_expected", 32'(if_q.size() != 0), 1);
        if (if_q.size() != 0) check("inst_to_if", inst_to_if, if_q.pop_front());
      end
      if (ok_flag_to_lsb) begin
        lsb_ok_cnt++;
        last_lsb_ok = cyc;
        check("lsb_ok_expected", 32'(lsb_q.size() != 0), 1);
        if (lsb_q.size() != 0) begin
          le = lsb_q.pop_front();
          if (le.wr) check("write_bytes_done_at_ok", 32'(wr_q.size()), 0);
          else       check("data_to_lsb", data_to_lsb, le.data);
        end
      end
    end
  end

  task automatic start_fetch(input logic [31:0] pc);
    if_q.push_back(ref_read(pc, 4));
    ena_from_if = 1'b1;
    pc_from_if  = pc;
  endtask

  task automatic start_lsb(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] d);
    lsb_exp_t e;
    if (wr) begin
      for (int i = 0; i < int'(sz); i++) begin
        wr_exp_t w;
        w.a = a + 32'(i);
        w.d = d[8*i +: 8];
        wr_q.push_back(w);
        ref_mem[a + 32'(i)] = d[8*i +: 8];
      end
      e.wr   = 1'b1;
      e.data = '0;
    end else begin
      e.wr   = 1'b0;
      e.data = ref_read(a, int'(sz));
    end
    lsb_q.push_back(e);
    ena_from_lsb     = 1'b1;
    wr_flag_from_lsb = wr;
    addr_from_lsb    = a;
    size_from_lsb    = sz;
    data_from_lsb    = d;
  endtask

  task automatic end_if();
    @(posedge clk); #1 ena_from_if = 1'b0;
  endtask

  task automatic end_lsb();
    @(posedge clk); #1 ena_from_lsb = 1'b0;
  endtask

  task automatic end_both();
    @(posedge clk); #1;
    ena_from_if  = 1'b0;
    ena_from_lsb = 1'b0;
  endtask

  task automatic wait_ok(input string name, input int if_target, input int lsb_target);
    int k;
    k = 0;
    while ((if_ok_cnt < if_target || lsb_ok_cnt < lsb_target) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(if_ok_cnt >= if_target && lsb_ok_cnt >= lsb_target), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_addr(input string name, input logic [31:0] a);
    int k;
    k = 0;
    while (mem_a !== a && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(name, mem_a, a);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_a"}, mem_a, 32'h0);
    check({tag, "_mem_dout"}, 32'(mem_dout), 32'h0);
    check({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
    check({tag, "_ok_if"}, 32'(ok_flag_to_if), 32'h0);
    check({tag, "_ok_lsb"}, 32'(ok_flag_to_lsb), 32'h0);
    check({tag, "_inst"}, inst_to_if, 32'h0);
    check({tag, "_data_lsb"}, data_to_lsb, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // Random LSB/fetch traffic on disjoint regions, IO back-pressure toggling meanwhile.
  task automatic fetch_driver();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 start_fetch(32'h1000 + 32'($urandom_range(0, 255)));
      end_if();
      wait_ok("rnd_fetch_done", if_ok_cnt + 1, 0);
    end
  endtask

  task automatic lsb_driver();
    int          op;
    logic [2:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      op = int'($urandom_range(0, 2));
      sz = 3'(1 << $urandom_range(0, 2));
      a  = (op == 2) ? 32'h0003_0000 + 32'($urandom_range(0, 252))
                     : 32'h2000 + 32'($urandom_range(0, 252));
      start_lsb(op != 0, a, sz, $urandom);
      end_lsb();
      wait_ok("rnd_lsb_done", 0, lsb_ok_cnt + 1);
    end
  endtask

  initial begin
    int          trace_a[10];
    int          trace_ok[10];
    int          t0;
    int          tok;
    int          okn;
    int          base_cnt;

    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    preload(32'h20, 8'hFF);  preload(32'h21, 8'h7F);
    preload(32'h22, 8'h55);  preload(32'h23, 8'hAA);
    preload(32'h0, 8'h44);   preload(32'h1, 8'h33);
    preload(32'h2, 8'h22);   preload(32'h3, 8'h11);
    preload(32'h200, 8'h93); preload(32'h201, 8'h00);
    preload(32'h202, 8'h10); preload(32'h203, 8'h00);
    preload(32'hFFFF_FFFE, 8'hAB); preload(32'hFFFF_FFFF, 8'hCD);
    for (int i = 0; i < 4; i++) preload(32'h300 + 32'(i), 8'(8'hC0 + i));
    for (int i = 0; i < 260; i++) preload(32'h1000 + 32'(i), 8'($urandom));
    for (int i = 0; i < 256; i++) preload(32'h2000 + 32'(i), 8'($urandom));

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Single fetch: address sequence and completion latency.
    start_fetch(32'h100);
    end_if();
    t0  = -1;
    tok = -1;
    okn = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      trace_a[k]  = int'(mem_a);
      trace_ok[k] = int'(ok_flag_to_if);
      if (mem_a === 32'h100 && t0 < 0) t0 = k;
      if (ok_flag_to_if === 1'b1) begin
        okn++;
        if (tok < 0) tok = k;
      end
    end
    check("fetch_first_addr_seen", 32'(t0 >= 0 && t0 <= 6), 1);
    if (t0 >= 0 && t0 <= 6)
      for (int j = 0; j < 4; j++) check("fetch_addr_seq", 32'(trace_a[t0+j]), 32'h100 + 32'(j));
    check("fetch_ok_latency", 32'(tok - t0), 5);
    check("fetch_ok_pulses", 32'(okn), 1);
    if (tok >= 0 && tok < 9) check("fetch_ok_one_cycle", 32'(trace_ok[tok+1]), 0);
    @(posedge clk); #1;

    // Simultaneous requests: LSB read is served first.
    base_cnt = if_ok_cnt;
    start_fetch(32'h0);
    start_lsb(1'b0, 32'h20, 3'd2, 32'h0);
    end_both();
    wait_ok("dual_done", base_cnt + 1, lsb_ok_cnt + 1);
    check("lsb_before_fetch", 32'(last_lsb_ok < last_if_ok), 1);

    // Word write then read-back.
    start_lsb(1'b1, 32'h40, 3'd4, 32'hDEAD_BEEF);
    end_lsb();
    wait_ok("write_word_done", 0, lsb_ok_cnt + 1);
    start_lsb(1'b0, 32'h40, 3'd4, 32'h0);
    end_lsb();
    wait_ok("readback_done", 0, lsb_ok_cnt + 1);

    // Fetch across the top of the address space.
    start_fetch(32'hFFFF_FFFE);
    end_if();
    wait_ok("wrap_fetch_done", if_ok_cnt + 1, 0);

    // Dropped fetch followed by a fresh one; the old one must never complete.
    base_cnt = if_ok_cnt;
    ena_from_if = 1'b1;
    pc_from_if  = 32'h300;
    end_if();
    wait_addr("drop_reach_byte1", 32'h301);
    @(posedge clk); #1 drop_flag_from_if = 1'b1;
    @(posedge clk); #1 drop_flag_from_if = 1'b0;
    start_fetch(32'h200);
    end_if();
    wait_ok("drop_refetch_done", base_cnt + 1, 0);
    repeat (10) @(posedge clk);
    #1 check("drop_ok_count", 32'(if_ok_cnt), 32'(base_cnt + 1));

    // IO write held off by a full buffer.
    io_buffer_full = 1'b1;
    start_lsb(1'b1, 32'h0003_0000, 3'd1, 32'h0000_005A);
    end_lsb();
    repeat (4) begin
      @(negedge clk);
      check("stall_no_write", 32'(mem_wr), 0);
    end
    @(posedge clk); #1 io_buffer_full = 1'b0;
    wait_ok("io_write_done", 0, lsb_ok_cnt + 1);

    // Reset in the middle of a load, then a frozen controller with a pending fetch.
    start_lsb(1'b0, 32'h20, 3'd4, 32'h0);
    end_lsb();
    wait_addr("mid_read_reached", 32'h21);
    @(posedge clk); #1 rst = 1'b1;
    lsb_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("mid_reset");
    @(posedge clk); #1 rst = 1'b0;
    start_fetch(32'h100);
    end_if();
    rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("frozen_mem_a", mem_a, 32'h0);
      check("frozen_ok", {30'b0, ok_flag_to_if, ok_flag_to_lsb}, 32'h0);
    end
    @(posedge clk); #1 rdy = 1'b1;
    wait_ok("thaw_fetch_done", if_ok_cnt + 1, 0);

    // Randomized concurrent traffic.
    fork
      begin
        fork
          fetch_driver();
          lsb_driver();
        join
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1 io_buffer_full = ($urandom_range(0, 3) == 0);
        end
        io_buffer_full = 1'b0;
      end
    join

    repeat (10) @(posedge clk);
    #1;
    check("if_queue_drained", 32'(if_q.size()), 0);
    check("lsb_queue_drained", 32'(lsb_q.size()), 0);
    check("write_queue_drained", 32'(wr_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
